// File: rtl/gshare_pht.sv
// gshare_pht: global-history pattern history table.
// A speculative global history register is XORed into the FETCH-stage PC
// index to select a saturating counter. The branch resolves in DECODE one
// cycle later. That resolution trains the counter and advances the
// committed history. A mispredict restores the speculative history from the
// committed one.
// Optional build macro: GSHARE_PHT_BYPASS_EN. When it is defined, a
// same-cycle update to the entry being looked up is forwarded to pred/hit.
module gshare_pht #(
  parameter int IWIDTH         = 6,
  parameter int HWIDTH         = 4,
  parameter int CWIDTH         = 2,
  parameter int TRUST_FALLBACK = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              do_lookup,
  input  logic [IWIDTH-1:0] pc_index,
  input  logic              fallback,
  output logic              pred,
  output logic              hit,
  input  logic              do_update,
  input  logic              last_taken,
  output logic              mispredict,
  output logic [HWIDTH-1:0] spec_hist
);

  localparam int ENTRIES = 2 ** IWIDTH;

  // Shift one outcome into a history register. The widened concatenation
  // keeps this legal for a single-bit history.
  function automatic logic [HWIDTH-1:0] hist_shift(input logic [HWIDTH-1:0] h,
                                                   input logic b);
    logic [HWIDTH:0] t;
    t = {h, b};
    return t[HWIDTH-1:0];
  endfunction

  // Step a saturating counter up or down, clamped to [0, 2**CWIDTH-1].
  function automatic logic [CWIDTH-1:0] sat_step(input logic [CWIDTH-1:0] c,
                                                 input logic up);
    logic [CWIDTH-1:0] r;
    if (up) r = (&c) ? c : c + 1'b1;
    else    r = (|c) ? c - 1'b1 : c;
    return r;
  endfunction

  // Value written into a freshly allocated entry.
  // Strong mode: saturated toward the static hint.
  // Weak mode: just on the hint's side of the midpoint.
  function automatic logic [CWIDTH-1:0] alloc_init(input logic fb);
    logic [CWIDTH-1:0] half;
    logic [CWIDTH-1:0] r;
    half = {1'b1, {(CWIDTH-1){1'b0}}};
    if (TRUST_FALLBACK != 0) r = fb ? {CWIDTH{1'b1}} : {CWIDTH{1'b0}};
    else                     r = fb ? half : half - 1'b1;
    return r;
  endfunction

  // Table and history state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [CWIDTH-1:0]  cnt_q [ENTRIES];
  logic [CWIDTH-1:0]  cnt_d [ENTRIES];
  logic [HWIDTH-1:0]  spec_hist_q, spec_hist_d;
  logic [HWIDTH-1:0]  commit_hist_q, commit_hist_d;
  logic [IWIDTH-1:0]  last_index_q, last_index_d;
  logic               last_pred_q, last_pred_d;

  logic [IWIDTH-1:0]  lookup_idx;
  logic [CWIDTH-1:0]  upd_cnt;

  // Hash the FETCH index with speculative history and precompute the trained
  // counter for the entry resolving in DECODE.
  always_comb begin
    lookup_idx = pc_index ^ IWIDTH'(spec_hist_q);
    upd_cnt    = sat_step(cnt_q[last_index_q], last_taken);
  end

  // Same-cycle prediction, hit and mispredict outputs.
  always_comb begin
    hit  = valid_q[lookup_idx];
    pred = hit ? cnt_q[lookup_idx][CWIDTH-1] : fallback;
`ifdef GSHARE_PHT_BYPASS_EN
    if (en && do_update && do_lookup && (lookup_idx == last_index_q)) begin
      hit  = 1'b1;
      pred = upd_cnt[CWIDTH-1];
    end
`endif
    mispredict = do_update && (last_taken != last_pred_q);
  end

  assign spec_hist = spec_hist_q;

  // Next-state logic.
  // A lookup captures the prediction, shifts the speculative history and
  // allocates an entry on a miss. An update trains the counter and commits
  // history. A mispredict overrides the lookup's history shift. The update
  // is applied after the allocation, so it wins on the same entry.
  always_comb begin
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    spec_hist_d   = spec_hist_q;
    commit_hist_d = commit_hist_q;
    last_index_d  = last_index_q;
    last_pred_d   = last_pred_q;
    if (en) begin
      if (do_lookup) begin
        last_index_d = lookup_idx;
        last_pred_d  = pred;
        spec_hist_d  = hist_shift(spec_hist_q, pred);
        if (!valid_q[lookup_idx]) begin
          valid_d[lookup_idx] = 1'b1;
          cnt_d[lookup_idx]   = alloc_init(fallback);
        end
      end
      if (do_update) begin
        cnt_d[last_index_q] = upd_cnt;
        commit_hist_d       = hist_shift(commit_hist_q, last_taken);
        if (mispredict) spec_hist_d = hist_shift(commit_hist_q, last_taken);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
      spec_hist_q   <= '0;
      commit_hist_q <= '0;
      last_index_q  <= '0;
      last_pred_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      spec_hist_q   <= spec_hist_d;
      commit_hist_q <= commit_hist_d;
      last_index_q  <= last_index_d;
      last_pred_q   <= last_pred_d;
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed testbench for gshare_pht (IWIDTH=6, HWIDTH=4, CWIDTH=2, weak init).
module tb_gshare_pht;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       do_lookup = 1'b0;
  logic [5:0] pc_index = '0;
  logic       fallback = 1'b0;
  logic       pred, hit, mispredict;
  logic       do_update = 1'b0;
  logic       last_taken = 1'b0;
  logic [3:0] spec_hist;

  int n_vec = 0;
  int n_bad = 0;
  logic exp_byp;

  gshare_pht #(.IWIDTH(6), .HWIDTH(4), .CWIDTH(2), .TRUST_FALLBACK(0)) dut (
    .clk(clk), .reset(reset), .en(en), .do_lookup(do_lookup),
    .pc_index(pc_index), .fallback(fallback), .pred(pred), .hit(hit),
    .do_update(do_update), .last_taken(last_taken),
    .mispredict(mispredict), .spec_hist(spec_hist)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; do_lookup = 1'b0; do_update = 1'b0;
    last_taken = 1'b0; fallback = 1'b0; pc_index = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0; #2; reset = 1'b1;
  endtask

  task automatic look(input logic [5:0] pc, input logic fb);
    do_lookup = 1'b1; pc_index = pc; fallback = fb;
  endtask

  initial begin
    // Reset state: outputs during reset
    idle();
    look(6'h05, 1'b1);
    do_update = 1'b1; last_taken = 1'b1;
    #2;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_pred", 32'(pred), 32'd1);
    chk("rst_hist", 32'(spec_hist), 32'd0);
    chk("rst_mp_taken", 32'(mispredict), 32'd1);
    last_taken = 1'b0; #1;
    chk("rst_mp_nt", 32'(mispredict), 32'd0);
    tick();
    reset = 1'b1; do_update = 1'b0;

    // First lookup allocates 0x05 weakly taken, history becomes 1
    @(negedge clk);
    chk("alloc_pred", 32'(pred), 32'd1);
    chk("alloc_hit", 32'(hit), 32'd0);
    tick();
    chk("hist_after_alloc", 32'(spec_hist), 32'h1);
    chk("v05", 32'(dut.valid_q[5]), 32'd1);
    chk("c05", 32'(dut.cnt_q[5]), 32'd2);
    fallback = 1'b0;
    @(negedge clk);
    chk("idx04_hit", 32'(hit), 32'd0);
    chk("idx04_pred", 32'(pred), 32'd0);
    tick();
    chk("idx04_last", 32'(dut.last_index_q), 32'h04);

    // Allocate weak not-taken, then three taken updates saturate at 3
    do_reset();
    look(6'h10, 1'b0);
    tick();
    chk("sat_c1", 32'(dut.cnt_q[16]), 32'd1);
    do_lookup = 1'b0; do_update = 1'b1; last_taken = 1'b1;
    @(negedge clk);
    chk("sat_mp", 32'(mispredict), 32'd1);
    tick(); chk("sat_c2", 32'(dut.cnt_q[16]), 32'd2);
    tick(); chk("sat_c3", 32'(dut.cnt_q[16]), 32'd3);
    tick(); chk("sat_c3b", 32'(dut.cnt_q[16]), 32'd3);

    // Counter at 0 stays at 0 under not-taken updates
    do_reset();
    look(6'h20, 1'b0);
    tick();
    do_lookup = 1'b0; do_update = 1'b1; last_taken = 1'b0;
    @(negedge clk);
    chk("floor_mp", 32'(mispredict), 32'd0);
    tick(); chk("floor_c0", 32'(dut.cnt_q[32]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("floor_hold", 32'(dut.cnt_q[32]), 32'd0);
    end

    // Four correct taken commits: commit and speculative history both 0xF
    do_reset();
    look(6'h00, 1'b1);
    tick();
    do_update = 1'b1; last_taken = 1'b1;
    begin
      logic [5:0] pcs [3];
      pcs[0] = 6'h01; pcs[1] = 6'h03; pcs[2] = 6'h07;
      for (int i = 0; i < 3; i++) begin
        pc_index = pcs[i];
        @(negedge clk);
        chk("hist_pred", 32'(pred), 32'd1);
        chk("hist_mp", 32'(mispredict), 32'd0);
        tick();
      end
    end
    do_lookup = 1'b0;
    tick();
    chk("commit_f", 32'(dut.commit_hist_q), 32'hF);
    chk("spec_f", 32'(spec_hist), 32'hF);
    do_update = 1'b0;
    look(6'h05, 1'b1);
    @(negedge clk);
    chk("idx0a_hit", 32'(hit), 32'd0);
    chk("idx0a_pred", 32'(pred), 32'd1);
    tick();
    chk("idx0a_last", 32'(dut.last_index_q), 32'h0A);
    chk("idx0a_cnt", 32'(dut.cnt_q[10]), 32'd2);

    // Mispredict with a concurrent lookup: history repaired from commit
    do_update = 1'b1; last_taken = 1'b0;
    look(6'h11, 1'b1);
    @(negedge clk);
    chk("rep_mp", 32'(mispredict), 32'd1);
    tick();
    chk("rep_spec", 32'(spec_hist), 32'hE);
    chk("rep_commit", 32'(dut.commit_hist_q), 32'hE);
    chk("rep_cnt0a", 32'(dut.cnt_q[10]), 32'd1);
    chk("rep_last", 32'(dut.last_index_q), 32'h1E);
    chk("rep_alloc", 32'(dut.valid_q[30]), 32'd1);

    // Asynchronous reset in the middle of an update
    do_reset();
    look(6'h08, 1'b1);
    tick();
    look(6'h09, 1'b1);
    do_update = 1'b1; last_taken = 1'b1;
    @(negedge clk);
    chk("mid_hit_pre", 32'(hit), 32'd1);
    reset = 1'b0; #1;
    chk("mid_hit", 32'(hit), 32'd0);
    chk("mid_spec", 32'(spec_hist), 32'd0);
    chk("mid_cnt", 32'(dut.cnt_q[8]), 32'd0);
    tick();
    reset = 1'b1;
    idle();
    look(6'h08, 1'b1);
    @(negedge clk);
    chk("realloc_hit", 32'(hit), 32'd0);
    tick();
    chk("realloc_cnt", 32'(dut.cnt_q[8]), 32'd2);
    chk("realloc_v", 32'(dut.valid_q[8]), 32'd1);

    // Same-index lookup concurrent with a taken update
    do_reset();
    look(6'h30, 1'b0);
    tick();
    do_update = 1'b1; last_taken = 1'b1;
`ifdef GSHARE_PHT_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    @(negedge clk);
    chk("byp_pred", 32'(pred), 32'(exp_byp));
    chk("byp_hit", 32'(hit), 32'd1);
    chk("byp_mp", 32'(mispredict), 32'd1);
    tick();
    chk("byp_cnt", 32'(dut.cnt_q[48]), 32'd2);

    // Stall: outputs live, no state change
    do_reset();
    en = 1'b0;
    look(6'h03, 1'b1);
    do_update = 1'b1; last_taken = 1'b1;
    @(negedge clk);
    chk("stall_pred", 32'(pred), 32'd1);
    chk("stall_mp", 32'(mispredict), 32'd1);
    tick();
    chk("stall_v", 32'(dut.valid_q[3]), 32'd0);
    chk("stall_spec", 32'(spec_hist), 32'd0);
    chk("stall_commit", 32'(dut.commit_hist_q), 32'd0);
    chk("stall_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
